// File: rtl/traffic_safety_monitor_if.sv
// traffic_safety_monitor_if: light-code inputs, fault clear and checked lamp
// outputs between the light controller (master) and the safety monitor (slave).
interface traffic_safety_monitor_if;
  logic [2:0] north_in, west_in, south_in, east_in;
  logic       clr_fault;
  logic [2:0] north_out, west_out, south_out, east_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  logic [7:0] fault_count;

  modport master (
    output north_in, west_in, south_in, east_in, clr_fault,
    input  north_out, west_out, south_out, east_out,
    input  fault, fault_code, fault_dir, fault_count
  );

  modport slave (
    input  north_in, west_in, south_in, east_in, clr_fault,
    output north_out, west_out, south_out, east_out,
    output fault, fault_code, fault_dir, fault_count
  );
endinterface

// File: rtl/traffic_safety_monitor.sv
// traffic_safety_monitor: conflict / sequence / dwell checker in front of the
// lamp drivers. Passes legal samples through with one cycle of latency and
// forces all lamps RED on a latched fault until cleared and re-armed.
// Optional stuck-input watchdog: define SAFETY_WDOG_EN.
// Direction index: N=0, W=1, S=2, E=3.

// Per-direction code classification against the previous sample.
module tsm_lane (
  input  logic [2:0] cur_i,
  input  logic [2:0] prev_i,
  output logic       illegal_o,
  output logic       nonred_o,
  output logic       chg_o,
  output logic       r2g_o,
  output logic       g2y_o,
  output logic       y2r_o,
  output logic       bad_seq_o
);
  localparam logic [2:0] GRN = 3'b001, YEL = 3'b010, RED = 3'b100;

  assign illegal_o = !(cur_i == GRN || cur_i == YEL || cur_i == RED);
  assign nonred_o  = (cur_i != RED);
  assign chg_o     = (cur_i != prev_i);
  assign r2g_o     = (prev_i == RED) && (cur_i == GRN);
  assign g2y_o     = (prev_i == GRN) && (cur_i == YEL);
  assign y2r_o     = (prev_i == YEL) && (cur_i == RED);
  assign bad_seq_o = chg_o && !(r2g_o || g2y_o || y2r_o);
endmodule

module traffic_safety_monitor #(
  parameter int GREEN_MIN   = 16,
  parameter int YELLOW_MIN  = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  traffic_safety_monitor_if.slave    bus
);
  localparam int NUM_LANES = 4;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [NUM_LANES-1:0][2:0] ALL_RED = {NUM_LANES{RED}};
  localparam logic [7:0] GMIN = 8'(GREEN_MIN);
  localparam logic [7:0] YMIN = 8'(YELLOW_MIN);

  typedef enum logic [1:0] {ARMING, RUN, FAULT} state_e;

  state_e                    state_q, state_d;
  logic [NUM_LANES-1:0][2:0] cur, prev_q, out_q, out_d;
  logic [7:0]                dwell_q, dwell_d, cnt_q, cnt_d;
  logic                      fault_q, fault_d;
  logic [2:0]                code_q, code_d, chk_code;
  logic [1:0]                dir_q, dir_d, chk_dir;
  logic [NUM_LANES-1:0]      illegal, nonred, chg, r2g, g2y, y2r, bad_seq;
  logic [NUM_LANES-1:0]      short_g, short_y;
  logic                      conflict, stuck;

  function automatic logic [1:0] low_idx(input logic [NUM_LANES-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) if (v[i]) idx = 2'(i);
    return idx;
  endfunction

  function automatic logic multi(input logic [NUM_LANES-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

  assign cur = {bus.east_in, bus.south_in, bus.west_in, bus.north_in};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tsm_lane u_lane (
      .cur_i(cur[i]), .prev_i(prev_q[i]),
      .illegal_o(illegal[i]), .nonred_o(nonred[i]), .chg_o(chg[i]),
      .r2g_o(r2g[i]), .g2y_o(g2y[i]), .y2r_o(y2r[i]), .bad_seq_o(bad_seq[i])
    );
  end

  assign conflict = multi(nonred);
  // dwell_q counts the samples of the code that is just being left
  assign short_g  = g2y & {NUM_LANES{dwell_q < GMIN}};
  assign short_y  = y2r & {NUM_LANES{dwell_q < YMIN}};

`ifdef SAFETY_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;

  // fires on the WDOG_CYCLES-th consecutive unchanged sample in RUN
  assign stuck = (state_q == RUN) && !(|chg) && (wd_q == WDW'(WDOG_CYCLES - 1));

  // unchanged-sample counter, only live in RUN
  always_comb wd_d = (state_q == RUN && !(|chg)) ? wd_q + 1'b1 : '0;

  // watchdog counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
`else
  // watchdog not built; the term below is constant zero
  assign stuck = 1'b0 & (WDOG_CYCLES != 0);
`endif

  // prioritised check result: lowest code wins, lowest direction within it
  always_comb begin
    chk_code = 3'd0;
    chk_dir  = 2'd0;
    if (|illegal) begin
      chk_code = 3'd1; chk_dir = low_idx(illegal);
    end else if (conflict) begin
      chk_code = 3'd2; chk_dir = low_idx(nonred);
    end else if (state_q == RUN) begin
      if (|bad_seq)      begin chk_code = 3'd3; chk_dir = low_idx(bad_seq); end
      else if (|short_g) begin chk_code = 3'd4; chk_dir = low_idx(short_g); end
      else if (|short_y) begin chk_code = 3'd5; chk_dir = low_idx(short_y); end
      else if (stuck)    begin chk_code = 3'd6; chk_dir = low_idx(nonred);  end
    end
  end

  // next state, lamp drive and fault bookkeeping
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    dwell_d = dwell_q;
    fault_d = fault_q;
    code_d  = code_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARMING: begin
        out_d   = ALL_RED;
        dwell_d = '0;
        if (chk_code == 3'd0 && |r2g && !multi(r2g)) begin
          state_d = RUN;
          out_d   = cur;
          dwell_d = 8'd1;
        end
      end
      RUN: begin
        out_d   = cur;
        dwell_d = (|chg) ? 8'd1 : ((dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1);
      end
      default: begin
        out_d   = ALL_RED;
        dwell_d = '0;
        // outside RUN chk_code only reflects illegal / conflict
        if (bus.clr_fault && chk_code == 3'd0) begin
          state_d = ARMING;
          fault_d = 1'b0;
          code_d  = 3'd0;
          dir_d   = 2'd0;
        end
      end
    endcase
    if (state_q != FAULT && chk_code != 3'd0) begin
      state_d = FAULT;
      out_d   = ALL_RED;
      dwell_d = '0;
      fault_d = 1'b1;
      code_d  = chk_code;
      dir_d   = chk_dir;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  // state and output registers; prev tracks the inputs in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARMING;
      prev_q  <= ALL_RED;
      out_q   <= ALL_RED;
      dwell_q <= '0;
      fault_q <= 1'b0;
      code_q  <= 3'd0;
      dir_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= cur;
      out_q   <= out_d;
      dwell_q <= dwell_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.north_out   = out_q[0];
  assign bus.west_out    = out_q[1];
  assign bus.south_out   = out_q[2];
  assign bus.east_out    = out_q[3];
  assign bus.fault       = fault_q;
  assign bus.fault_code  = code_q;
  assign bus.fault_dir   = dir_q;
  assign bus.fault_count = cnt_q;
endmodule

// File: doc/traffic_safety_monitor.md
# traffic_safety_monitor

Downstream conflict monitor between the 4-way traffic light controller and the lamp drivers. It consumes the controller's four 3-bit one-hot light codes and checks encoding, cross-direction conflicts, phase sequence and minimum dwell times. Checked lights pass to the lamp outputs with one cycle of latency. On any violation it latches a fault, forces all lamps RED and holds them there until software clears the fault and the controller cycle re-synchronises.

## Interface
- GREEN_MIN, 16: minimum consecutive GREEN samples required before a GREEN→YELLOW change.
- YELLOW_MIN, 4: minimum consecutive YELLOW samples required before a YELLOW→RED change.
- WDOG_CYCLES, 64: stuck-input limit in cycles. Used only with SAFETY_WDOG_EN.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- north_in, west_in, south_in, east_in  in  3 each  controller light codes: GREEN=001, YELLOW=010, RED=100.
- clr_fault  in  1  single-cycle fault clear request.
- north_out, west_out, south_out, east_out  out  3 each  checked lamp drive.
- fault  out  1  high while in FAULT.
- fault_code  out  3  0 none, 1 ILLEGAL_CODE, 2 CONFLICT, 3 BAD_SEQ, 4 SHORT_GREEN, 5 SHORT_YELLOW, 6 STUCK.
- fault_dir  out  2  offending direction: N=0, W=1, S=2, E=3.
- fault_count  out  8  number of FAULT entries since reset, saturates at 255.

## Operation
- Registers:
  - prev[4]: last sampled input codes. Reset value RED.
  - dwell: 8-bit count of consecutive identical samples of the active direction. Saturates.
  - state ∈ {ARMING, RUN, FAULT}.
- Checks, evaluated each edge on the current inputs versus prev:
  - ILLEGAL_CODE: any input not in {001, 010, 100}.
  - CONFLICT: more than one input non-RED.
  - BAD_SEQ: any per-direction change other than RED→GREEN, GREEN→YELLOW or YELLOW→RED.
  - SHORT_GREEN: GREEN→YELLOW with dwell < GREEN_MIN.
  - SHORT_YELLOW: YELLOW→RED with dwell < YELLOW_MIN.
- ARMING (reset state):
  - Outputs are all RED.
  - Only ILLEGAL_CODE and CONFLICT are checked.
  - A RED→GREEN change on exactly one direction moves to RUN. That sample is passed through and dwell is set to 1.
- RUN:
  - All checks are active.
  - If the sample passes, outputs register the inputs.
  - dwell resets to 1 on any change of the active code, otherwise increments.
- FAULT:
  - Entered from any check failure. A failing sample never reaches the outputs.
  - Outputs are forced to 100 on all four directions.
  - fault=1; fault_code and fault_dir are latched; fault_count increments.
- Priority: if several checks fail together, the lowest fault_code wins. fault_dir is the lowest-index offending direction.
- Clear:
  - clr_fault in FAULT, with current inputs legal and non-conflicting: go to ARMING next edge, fault=0, fault_code=0, fault_dir=0.
  - Otherwise the clear is ignored.
  - clr_fault in ARMING or RUN has no effect.
- prev updates every cycle in all states.

## Timing
- Reset values:
  - All *_out = 100.
  - fault=0, fault_code=0, fault_dir=0, fault_count=0.
  - state=ARMING, dwell=0, prev=all RED.
- rst_n low mid-operation returns everything to reset values immediately, including fault_count.
- Latency: input sampled at edge k appears on *_out after edge k. A fault detected at edge k gives fault=1 and all-RED outputs after edge k.
- The nominal controller sequence (16 GREEN, 4 YELLOW, rotating N→W→S→E, with the next GREEN in the same cycle as the previous RED) is legal and produces no fault.
- A detection and a clr_fault in the same cycle: detection wins.

## Configuration
- SAFETY_WDOG_EN defined:
  - In RUN, a counter tracks cycles with all inputs unchanged.
  - When the counter reaches WDOG_CYCLES, enter FAULT with code 6 (STUCK). fault_dir is the active direction, or 0 if all inputs are RED.
  - The counter resets on any input change and on leaving RUN.
- SAFETY_WDOG_EN undefined: no watchdog logic is built and code 6 never occurs.

## Test plan
- Nominal: reset, then run the controller sequence for 3 rotations. *_out equals the inputs delayed 1 cycle; fault stays 0.
- Conflict: during WestGreen, force north_in=001. Next edge: fault=1, code=2, dir=0, all outputs 100, fault_count=1.
- Short yellow: east YELLOW for 2 cycles, then RED. Result: code=5, dir=3.
- Illegal/sequence: south_in=011 gives code=1, dir=2. After clear and re-arm, north GREEN→RED gives code=3, dir=0.
- Clear/re-arm: clr_fault with legal inputs. Outputs stay RED until the next RED→GREEN, then pass-through resumes. fault_code=0 and fault_count=1.
- Watchdog: with the macro defined and WDOG_CYCLES=64, hold inputs constant in RUN. Fault code 6 on the 64th unchanged cycle. With the macro undefined, no fault. Asserting rst_n low while in FAULT clears all outputs to their reset values.
